// File: rtl/ysyx_23060025_ex_issue_pkg.sv
// ysyx_23060025_ex_issue_pkg
// Purpose: shared widths, ALU operation codes, branch-type codes and the
//          held-instruction control payload for the execute-issue stage.
// Ports:   none (package).
package ysyx_23060025_ex_issue_pkg;

  localparam int unsigned EXI_DATA_LEN = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned ALU_OP_W     = 4;
  localparam int unsigned BR_W         = 3;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD           = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB           = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LESS_SIGNED   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LESS_UNSIGNED = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND           = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR            = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR           = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL           = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL           = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA           = 4'd9;

  // Branch type codes
  localparam logic [BR_W-1:0] BR_NONE = 3'd0;
  localparam logic [BR_W-1:0] BR_BEQ  = 3'd1;
  localparam logic [BR_W-1:0] BR_BNE  = 3'd2;
  localparam logic [BR_W-1:0] BR_BLT  = 3'd3;
  localparam logic [BR_W-1:0] BR_BGE  = 3'd4;
  localparam logic [BR_W-1:0] BR_BLTU = 3'd5;
  localparam logic [BR_W-1:0] BR_BGEU = 3'd6;
  localparam logic [BR_W-1:0] BR_JUMP = 3'd7;

  // Control fields carried with the held instruction
  typedef struct packed {
    logic [BR_W-1:0]   br_type;
    logic              wb_en;
    logic [REG_AW-1:0] rd;
  } exi_ctrl_t;

  // Branch resolution from ALU flags; the IDU picks SUB / LESS_* so that
  // zero means equal and less means signed/unsigned less-than.
  function automatic logic br_taken(input logic [BR_W-1:0] br_type,
                                    input logic zero, input logic less);
    logic tk;
    tk = 1'b0;
    case (br_type)
      BR_BEQ:           tk = zero;
      BR_BNE:           tk = ~zero;
      BR_BLT, BR_BLTU:  tk = less;
      BR_BGE, BR_BGEU:  tk = ~less;
      BR_JUMP:          tk = 1'b1;
      default:          tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/ysyx_23060025_fwd_mux.sv
// ysyx_23060025_fwd_mux
// Purpose: operand bypass selector for one source register.
//          Priority: retiring EX instruction, then WB stage, then regfile.
//          Register x0 always reads zero and is never bypassed.
// Ports:
//   i_rs_addr           source register index
//   i_ex_en/rd/data     instruction retiring from this stage this cycle
//   i_wb_en/rd/data     WB-stage write
//   i_rf_data           regfile read data
//   o_data              selected operand
module ysyx_23060025_fwd_mux
  import ysyx_23060025_ex_issue_pkg::*;
#(
  parameter int unsigned DATA_LEN = EXI_DATA_LEN
) (
  input  logic [REG_AW-1:0]   i_rs_addr,
  input  logic                i_ex_en,
  input  logic [REG_AW-1:0]   i_ex_rd,
  input  logic [DATA_LEN-1:0] i_ex_data,
  input  logic                i_wb_en,
  input  logic [REG_AW-1:0]   i_wb_rd,
  input  logic [DATA_LEN-1:0] i_wb_data,
  input  logic [DATA_LEN-1:0] i_rf_data,
  output logic [DATA_LEN-1:0] o_data
);

  logic w_is_zero;
  logic w_hit_ex;
  logic w_hit_wb;

  assign w_is_zero = (i_rs_addr == '0);
  assign w_hit_ex  = i_ex_en & (i_ex_rd == i_rs_addr);
  assign w_hit_wb  = i_wb_en & (i_wb_rd == i_rs_addr);

  always_comb begin
    o_data = i_rf_data;
    if (w_is_zero)     o_data = '0;
    else if (w_hit_ex) o_data = i_ex_data;
    else if (w_hit_wb) o_data = i_wb_data;
  end

endmodule

// File: rtl/ysyx_23060025_ex_issue.sv
// ysyx_23060025_ex_issue
// Purpose: one-entry execute-issue register between IDU and ALU. Captures a
//          decoded instruction with bypassed operands, presents them to the
//          external ALU, resolves branches/jumps from the ALU flags, forms the
//          writeback value and raises a one-cycle fetch redirect on retire.
// Optional: define YSYX_23060025_EXI_PERF_EN to add perf_issue_cnt and
//          perf_redirect_cnt outputs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready + in_*      IDU instruction handshake and payload
//   wb_en/wb_rd/wb_data           WB-stage bypass
//   flush                         kill the held instruction
//   alu_src1/alu_src2/alu_control operands to the ALU
//   alu_result/alu_zero/alu_less  ALU outputs
//   out_valid/out_ready + out_*   retiring instruction to next stage
//   redirect_valid/redirect_pc    taken branch/jump target to fetch
module ysyx_23060025_ex_issue
  import ysyx_23060025_ex_issue_pkg::*;
#(
  parameter int unsigned DATA_LEN = EXI_DATA_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_imm,
  input  logic [DATA_LEN-1:0] in_rs1_data,
  input  logic [DATA_LEN-1:0] in_rs2_data,
  input  logic [REG_AW-1:0]   in_rs1_addr,
  input  logic [REG_AW-1:0]   in_rs2_addr,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic                in_src1_sel,
  input  logic                in_src2_sel,
  input  logic [ALU_OP_W-1:0] in_alu_control,
  input  logic [BR_W-1:0]     in_br_type,
  input  logic                in_jalr,
  input  logic                in_wb_en,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [DATA_LEN-1:0] wb_data,
  input  logic                flush,
  output logic [DATA_LEN-1:0] alu_src1,
  output logic [DATA_LEN-1:0] alu_src2,
  output logic [ALU_OP_W-1:0] alu_control,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic                alu_zero,
  input  logic                alu_less,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_pc,
  output logic [DATA_LEN-1:0] out_result,
  output logic [REG_AW-1:0]   out_rd,
  output logic                out_wb_en,
`ifdef YSYX_23060025_EXI_PERF_EN
  output logic [31:0]         perf_issue_cnt,
  output logic [31:0]         perf_redirect_cnt,
`endif
  output logic                redirect_valid,
  output logic [DATA_LEN-1:0] redirect_pc
);

  logic                r_valid;
  logic [DATA_LEN-1:0] r_pc;
  logic [DATA_LEN-1:0] r_imm;
  logic [DATA_LEN-1:0] r_rs1;
  logic [DATA_LEN-1:0] r_rs2;
  logic [DATA_LEN-1:0] r_target;
  logic                r_src1_sel;
  logic                r_src2_sel;
  logic [ALU_OP_W-1:0] r_alu_control;
  exi_ctrl_t           r_ctrl;

  logic                w_out_valid;
  logic                w_out_fire;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_taken;
  logic                w_redirect;
  logic                w_out_wb_en;
  logic [DATA_LEN-1:0] w_out_result;
  logic [DATA_LEN-1:0] w_rs1;
  logic [DATA_LEN-1:0] w_rs2;
  logic [DATA_LEN-1:0] w_tgt_sum;
  logic [DATA_LEN-1:0] w_target;

  // Retire side: flush or reset kill the held entry in the same cycle
  assign w_out_valid  = r_valid & ~flush & ~rst;
  assign w_out_fire   = w_out_valid & out_ready;
  assign w_taken      = br_taken(r_ctrl.br_type, alu_zero, alu_less);
  assign w_redirect   = w_out_fire & w_taken;
  assign w_out_wb_en  = r_ctrl.wb_en & (r_ctrl.rd != '0);
  assign w_out_result = (r_ctrl.br_type == BR_JUMP) ? (r_pc + DATA_LEN'(4)) : alu_result;

  // Accept side: refill only when empty or draining, never on a redirect
  assign w_in_ready = ~rst & ~flush & ~w_redirect & (~r_valid | w_out_fire);
  assign w_in_fire  = in_valid & w_in_ready;

  // Bypass sources: the retiring instruction first, then WB
  ysyx_23060025_fwd_mux #(.DATA_LEN(DATA_LEN)) u_fwd_rs1 (
    .i_rs_addr (in_rs1_addr),
    .i_ex_en   (w_out_fire & w_out_wb_en),
    .i_ex_rd   (r_ctrl.rd),
    .i_ex_data (w_out_result),
    .i_wb_en   (wb_en),
    .i_wb_rd   (wb_rd),
    .i_wb_data (wb_data),
    .i_rf_data (in_rs1_data),
    .o_data    (w_rs1)
  );

  ysyx_23060025_fwd_mux #(.DATA_LEN(DATA_LEN)) u_fwd_rs2 (
    .i_rs_addr (in_rs2_addr),
    .i_ex_en   (w_out_fire & w_out_wb_en),
    .i_ex_rd   (r_ctrl.rd),
    .i_ex_data (w_out_result),
    .i_wb_en   (wb_en),
    .i_wb_rd   (wb_rd),
    .i_wb_data (wb_data),
    .i_rf_data (in_rs2_data),
    .o_data    (w_rs2)
  );

  // Branch/jump target computed at capture; JALR clears bit 0
  assign w_tgt_sum = (in_jalr ? w_rs1 : in_pc) + in_imm;
  assign w_target  = in_jalr ? {w_tgt_sum[DATA_LEN-1:1], 1'b0} : w_tgt_sum;

  // Entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_imm         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_target      <= '0;
      r_src1_sel    <= 1'b0;
      r_src2_sel    <= 1'b0;
      r_alu_control <= '0;
      r_ctrl        <= '0;
    end else begin
      if (flush)           r_valid <= 1'b0;
      else if (w_in_fire)  r_valid <= 1'b1;
      else if (w_out_fire) r_valid <= 1'b0;

      if (w_in_fire) begin
        r_pc           <= in_pc;
        r_imm          <= in_imm;
        r_rs1          <= w_rs1;
        r_rs2          <= w_rs2;
        r_target       <= w_target;
        r_src1_sel     <= in_src1_sel;
        r_src2_sel     <= in_src2_sel;
        r_alu_control  <= in_alu_control;
        r_ctrl.br_type <= in_br_type;
        r_ctrl.wb_en   <= in_wb_en;
        r_ctrl.rd      <= in_rd;
      end
    end
  end

  // Operand selection from held state only, so ALU inputs stay stable
  assign alu_src1    = r_src1_sel ? r_pc  : r_rs1;
  assign alu_src2    = r_src2_sel ? r_imm : r_rs2;
  assign alu_control = r_alu_control;

  assign in_ready       = w_in_ready;
  assign out_valid      = w_out_valid;
  assign out_pc         = r_pc;
  assign out_result     = w_out_result;
  assign out_rd         = r_ctrl.rd;
  assign out_wb_en      = w_out_wb_en;
  assign redirect_valid = w_redirect;
  assign redirect_pc    = r_target;

`ifdef YSYX_23060025_EXI_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_redirect;

  // Retire and redirect counters; wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issue    <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (w_out_fire) r_perf_issue    <= r_perf_issue + 32'd1;
      if (w_redirect) r_perf_redirect <= r_perf_redirect + 32'd1;
    end
  end

  assign perf_issue_cnt    = r_perf_issue;
  assign perf_redirect_cnt = r_perf_redirect;
`endif

endmodule

// File: tb/tb_ysyx_23060025_ex_issue.sv
// tb_ysyx_23060025_ex_issue
// Purpose: self-checking bench for the execute-issue stage. A behavioural ALU
//          closes the loop; expected retirements are queued on capture and
//          compared when the stage retires them.
module tb_ysyx_23060025_ex_issue;
  import ysyx_23060025_ex_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic        in_src1_sel, in_src2_sel;
  logic [3:0]  in_alu_control;
  logic [2:0]  in_br_type;
  logic        in_jalr, in_wb_en;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero, alu_less;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_23060025_EXI_PERF_EN
  logic [31:0] perf_issue_cnt, perf_redirect_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060025_ex_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd(in_rd),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_alu_control(in_alu_control), .in_br_type(in_br_type),
    .in_jalr(in_jalr), .in_wb_en(in_wb_en),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
`ifdef YSYX_23060025_EXI_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_OP_ADD:           r = a + b;
      ALU_OP_SUB:           r = a - b;
      ALU_OP_LESS_SIGNED:   r = {31'd0, $signed(a) < $signed(b)};
      ALU_OP_LESS_UNSIGNED: r = {31'd0, a < b};
      ALU_OP_AND:           r = a & b;
      ALU_OP_OR:            r = a | b;
      ALU_OP_XOR:           r = a ^ b;
      ALU_OP_SLL:           r = a << b[4:0];
      ALU_OP_SRL:           r = a >> b[4:0];
      ALU_OP_SRA:           r = $signed(a) >>> b[4:0];
      default:              r = 32'd0;
    endcase
    return r;
  endfunction

  // Behavioural ALU driven by the stage's operand outputs
  always_comb begin
    alu_result = alu_ref(alu_control, alu_src1, alu_src2);
    alu_zero   = (alu_result == 32'd0);
    alu_less   = (alu_control == ALU_OP_LESS_UNSIGNED) ? (alu_src1 < alu_src2)
                                                       : ($signed(alu_src1) < $signed(alu_src2));
  end

  typedef struct {
    logic [31:0] pc, imm, r1d, r2d, v1, v2;
    logic [4:0]  r1a, r2a, rd;
    logic        s1, s2, jalr, wbe;
    logic [3:0]  op;
    logic [2:0]  br;
  } instr_t;

  typedef struct {
    logic [31:0] pc, result, target;
    logic [4:0]  rd;
    logic        wb_en, taken;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_issue = 0;
  int   exp_redir = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // v1/v2 are the architecturally correct operand values for the instruction
  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] r1a, input logic [31:0] r1d,
                                input logic [31:0] v1, input logic [4:0] r2a, input logic [31:0] r2d,
                                input logic [31:0] v2, input logic [31:0] imm, input logic s1,
                                input logic s2, input logic [3:0] op, input logic [2:0] br,
                                input logic jalr, input logic [4:0] rd, input logic wbe);
    instr_t t;
    t.pc = pc; t.r1a = r1a; t.r1d = r1d; t.v1 = v1; t.r2a = r2a; t.r2d = r2d; t.v2 = v2;
    t.imm = imm; t.s1 = s1; t.s2 = s2; t.op = op; t.br = br; t.jalr = jalr; t.rd = rd; t.wbe = wbe;
    return t;
  endfunction

  function automatic exp_t model(input instr_t t);
    exp_t        m;
    logic [31:0] a, b, sum;
    logic        tk;
    a = t.s1 ? t.pc  : t.v1;
    b = t.s2 ? t.imm : t.v2;
    case (t.br)
      BR_BEQ:  tk = (a == b);
      BR_BNE:  tk = (a != b);
      BR_BLT:  tk = ($signed(a) <  $signed(b));
      BR_BGE:  tk = ($signed(a) >= $signed(b));
      BR_BLTU: tk = (a <  b);
      BR_BGEU: tk = (a >= b);
      BR_JUMP: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    sum = t.jalr ? (t.v1 + t.imm) : (t.pc + t.imm);
    if (t.jalr) sum[0] = 1'b0;
    m.pc     = t.pc;
    m.result = (t.br == BR_JUMP) ? (t.pc + 32'd4) : alu_ref(t.op, a, b);
    m.target = sum;
    m.rd     = t.rd;
    m.wb_en  = t.wbe && (t.rd != 5'd0);
    m.taken  = tk;
    return m;
  endfunction

  // One clock: sample (optionally already 1ns past negedge), score, advance
  task automatic cycle(input bit pre_sampled, output bit in_fired);
    exp_t e;
    if (!pre_sampled) #1;
    in_fired = in_valid & in_ready;
    if (out_valid & out_ready) begin
      if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_result", out_result, e.result);
        check("out_rd", 32'(out_rd), 32'(e.rd));
        check("out_wb_en", 32'(out_wb_en), 32'(e.wb_en));
        check("redirect_valid", 32'(redirect_valid), 32'(e.taken));
        if (e.taken) begin
          check("redirect_pc", redirect_pc, e.target);
          check("in_ready_on_redirect", 32'(in_ready), 32'd0);
          exp_redir++;
        end
        exp_issue++;
      end
    end else begin
      check("no_redirect", 32'(redirect_valid), 32'd0);
    end
    if (in_fired) sb.push_back(nxt);
    @(negedge clk);
  endtask

  task automatic issue(input instr_t t, output int waited);
    bit f;
    in_valid = 1'b1; in_pc = t.pc; in_imm = t.imm;
    in_rs1_addr = t.r1a; in_rs1_data = t.r1d; in_rs2_addr = t.r2a; in_rs2_data = t.r2d;
    in_src1_sel = t.s1; in_src2_sel = t.s2; in_alu_control = t.op; in_br_type = t.br;
    in_jalr = t.jalr; in_rd = t.rd; in_wb_en = t.wbe;
    nxt = model(t);
    waited = 0; f = 1'b0;
    while (!f && waited < 20) begin
      cycle(1'b0, f);
      waited++;
    end
    if (!f) check("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle(1'b0, f);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    bit          f;
    logic [31:0] vals [4];
    logic [31:0] a, b;
    logic [2:0]  br;
    logic [3:0]  op;

    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_imm = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd = '0; in_src1_sel = 1'b0; in_src2_sel = 1'b0;
    in_alu_control = '0; in_br_type = '0; in_jalr = 1'b0; in_wb_en = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'd0);
    check("rst_alu_src1", alu_src1, 32'd0);
    check("rst_alu_src2", alu_src2, 32'd0);
`ifdef YSYX_23060025_EXI_PERF_EN
    check("rst_perf_issue", perf_issue_cnt, 32'd0);
    check("rst_perf_redirect", perf_redirect_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic ADD: 5 + imm 7
    issue(mk(32'h8000_0000, 5'd5, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 32'd7, 1'b0, 1'b1,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd3, 1'b1), w);
    #1;
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_alu_src1", alu_src1, 32'd5);
    check("add_alu_src2", alu_src2, 32'd7);
    check("add_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b1, f);
    drain();

    // Back-to-back dependency through the retiring result
    issue(mk(32'h10, 5'd2, 32'd3, 32'd3, 5'd0, 32'd0, 32'd0, 32'd4, 1'b0, 1'b1,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd1, 1'b1), w);
    issue(mk(32'h14, 5'd1, 32'hDEAD, 32'd7, 5'd0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1,
             ALU_OP_SUB, BR_NONE, 1'b0, 5'd2, 1'b1), w);
    check("b2b_no_stall", 32'(w), 32'd1);
    drain();

    // Retiring result outranks WB; x0 source ignores garbage
    issue(mk(32'h20, 5'd0, 32'h55, 32'd0, 5'd0, 32'd0, 32'd0, 32'd10, 1'b0, 1'b1,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd7, 1'b1), w);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'd500;
    issue(mk(32'h24, 5'd7, 32'h0, 32'd10, 5'd0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd8, 1'b1), w);
    wb_en = 1'b0;
    drain();

    // WB bypass on an empty stage; rd=0 suppresses out_wb_en
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'd100;
    issue(mk(32'h30, 5'd4, 32'd0, 32'd100, 5'd6, 32'd20, 32'd20, 32'd0, 1'b0, 1'b0,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd9, 1'b1), w);
    wb_rd = 5'd0; wb_data = 32'd99;
    drain();
    issue(mk(32'h34, 5'd0, 32'h55, 32'd0, 5'd0, 32'd0, 32'd0, 32'd3, 1'b0, 1'b1,
             ALU_OP_ADD, BR_NONE, 1'b0, 5'd0, 1'b1), w);
    wb_en = 1'b0;
    drain();

    // Dependent chain at full throughput
    for (int i = 0; i < 8; i++) begin
      issue(mk(32'h40 + 32'(i * 4), (i == 0) ? 5'd0 : 5'(9 + i), 32'hBAD0_0000, 32'(i),
               5'd0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1, ALU_OP_ADD, BR_NONE, 1'b0,
               5'(10 + i), 1'b1), w);
      if (i > 0) check("stream_throughput", 32'(w), 32'd1);
    end
    drain();

    // BLT taken (-1 < 1), then BLTU not taken
    issue(mk(32'h100, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd1, 32'h10, 1'b0, 1'b0,
             ALU_OP_LESS_SIGNED, BR_BLT, 1'b0, 5'd0, 1'b0), w);
    issue(mk(32'h104, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'd1, 32'h10, 1'b0, 1'b0,
             ALU_OP_LESS_UNSIGNED, BR_BLTU, 1'b0, 5'd0, 1'b0), w);
    drain();

    // JALR and JAL
    issue(mk(32'h400, 5'd3, 32'h2003, 32'h2003, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1,
             ALU_OP_ADD, BR_JUMP, 1'b1, 5'd1, 1'b1), w);
    issue(mk(32'h1000, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h20, 1'b1, 1'b1,
             ALU_OP_ADD, BR_JUMP, 1'b0, 5'd1, 1'b1), w);
    drain();

    // Taken BEQ held by backpressure
    out_ready = 1'b0;
    issue(mk(32'h200, 5'd5, 32'd9, 32'd9, 5'd6, 32'd9, 32'd9, 32'd8, 1'b0, 1'b0,
             ALU_OP_SUB, BR_BEQ, 1'b0, 5'd0, 1'b0), w);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_alu_src1", alu_src1, 32'd9);
      check("hold_alu_src2", alu_src2, 32'd9);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, f);
    end
    out_ready = 1'b1;
    drain();

    // Flush of a held, ready-to-retire entry
    issue(mk(32'h300, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b1,
             ALU_OP_ADD, BR_JUMP, 1'b0, 5'd1, 1'b1), w);
    flush = 1'b1;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_redirect", 32'(redirect_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_back());
    cycle(1'b1, f);
    flush = 1'b0;
    #1;
    check("flush_entry_gone", 32'(out_valid), 32'd0);
`ifdef YSYX_23060025_EXI_PERF_EN
    check("flush_perf_issue", perf_issue_cnt, 32'(exp_issue));
    check("flush_perf_redirect", perf_redirect_cnt, 32'(exp_redir));
`endif
    cycle(1'b1, f);

    // Reset while holding a taken jump
    issue(mk(32'h500, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'h40, 1'b1, 1'b1,
             ALU_OP_ADD, BR_JUMP, 1'b0, 5'd1, 1'b1), w);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_redirect", 32'(redirect_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_back());
    cycle(1'b1, f);
    rst = 1'b0;
    exp_issue = 0;
    exp_redir = 0;
    #1;
    check("midrst_entry_gone", 32'(out_valid), 32'd0);
    cycle(1'b1, f);

    // Conditional branch mix over corner operands
    for (int i = 0; i < 24; i++) begin
      a  = vals[$urandom_range(0, 3)];
      b  = vals[$urandom_range(0, 3)];
      br = 3'(1 + (i % 6));
      op = (br == BR_BEQ || br == BR_BNE) ? ALU_OP_SUB :
           (br == BR_BLT || br == BR_BGE) ? ALU_OP_LESS_SIGNED : ALU_OP_LESS_UNSIGNED;
      issue(mk(32'h3000 + 32'(i * 4), 5'd1, a, a, 5'd2, b, b, 32'h40, 1'b0, 1'b0,
               op, br, 1'b0, 5'd0, 1'b0), w);
    end
    drain();

`ifdef YSYX_23060025_EXI_PERF_EN
    check("perf_issue", perf_issue_cnt, 32'(exp_issue));
    check("perf_redirect", perf_redirect_cnt, 32'(exp_redir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
